sll_seq: RTL and testbench

- Sequential shift-logical-left unit: the left-shift counterpart of the catalog's right-shift register element.
- Accepts an operand and a shift amount over a valid/ready handshake, shifts left one bit per enabled cycle, and presents the result over a second valid/ready handshake.
- Sits in the Computer Architecture Elements Catalog as the multi-cycle, area-cheap shifter for datapaths that tolerate variable latency.

---
 rtl/sll_pkg.sv | 16 +
 rtl/sll_amt_cnt.sv | 30 +++
 rtl/sll_seq.sv | 110 +++++++++++
 tb/tb_sll_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sll_pkg.sv
// rtl/sll_pkg.sv - shared types and helpers for the sequential left shifter
package sll_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sll_state_t;

  // Width of a counter that must hold every value from 0 to n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Shifting by n or more clears the operand, so cap the count at n
  function automatic int sat_amt(input int amt, input int n);
    return (amt > n) ? n : amt;
  endfunction

endpackage

// File: rtl/sll_amt_cnt.sv
// rtl/sll_amt_cnt.sv - loadable down-counter with a count==1 terminal flag
module sll_amt_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_one
);

  // Load has priority over decrement; nothing moves while en is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_val;
      end else if (dec) begin
        count <= count - W'(1);
      end
    end
  end

  assign is_one = (count == W'(1));

endmodule

// File: rtl/sll_seq.sv
// rtl/sll_seq.sv - multi-cycle shift-left-logical unit; SLL_STICKY_EN adds the sticky output
module sll_seq
  import sll_pkg::*;
#(
  parameter int n     = 8,
  parameter int amt_n = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     d,
  input  logic [amt_n-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     out,
  output logic             busy
`ifdef SLL_STICKY_EN
  ,
  output logic             sticky
`endif
);

  localparam int CW = cnt_w(n);

  sll_state_t      state;
  sll_state_t      state_nxt;
  logic [CW-1:0]   eff_amt;
  logic [CW-1:0]   count;
  logic            is_one;
  logic            accept;
  logic            take;
  logic            shifting;

  assign eff_amt   = CW'(sat_amt(int'(amt), n));
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  // A finishing result frees the unit in the same cycle, so a new operand needs no bubble
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = en & in_valid & in_ready;
  assign take      = en & out_valid & out_ready;
  assign shifting  = en & (state == SHIFT);

  sll_amt_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (accept),
    .load_val (eff_amt),
    .dec      (shifting),
    .count    (count),
    .is_one   (is_one)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: load restarts the op, last shift finishes it, a taken result without a new operand idles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (eff_amt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (en && is_one) state_nxt = DONE;
      end
      DONE: begin
        if (accept) begin
          state_nxt = (eff_amt == '0) ? DONE : SHIFT;
        end else if (take) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result register: load the operand, then shift one bit per enabled SHIFT cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (accept) begin
      out <= d;
    end else if (shifting) begin
      out <= {out[n-2:0], 1'b0};
    end
  end

`ifdef SLL_STICKY_EN
  // Collect every bit that falls off the top during the current operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky <= 1'b0;
    end else if (accept) begin
      sticky <= 1'b0;
    end else if (shifting) begin
      sticky <= sticky | out[n-1];
    end
  end
`endif

endmodule

// File: tb/tb_sll_seq.sv
// tb/tb_sll_seq.sv - directed self-checking bench for sll_seq
module tb_sll_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       out_ready;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic [2:0] amt;
  logic       out_valid;
  logic [7:0] out;
  logic       busy;

  logic       in_valid4;
  logic       in_ready4;
  logic [3:0] d4;
  logic [2:0] amt4;
  logic       out_valid4;
  logic [3:0] out4;
  logic       busy4;

`ifdef SLL_STICKY_EN
  logic       sticky;
  logic       sticky4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sll_seq #(.n(8), .amt_n(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .amt       (amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
`ifdef SLL_STICKY_EN
    ,
    .sticky    (sticky)
`endif
  );

  sll_seq #(.n(4), .amt_n(3)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .d         (d4),
    .amt       (amt4),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out       (out4),
    .busy      (busy4)
`ifdef SLL_STICKY_EN
    ,
    .sticky    (sticky4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; out_ready = 1'b0;
    in_valid = 1'b0; d = '0; amt = '0;
    in_valid4 = 1'b0; d4 = '0; amt4 = '0;
    tick();
    tick();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready4 got %b exp 1", in_ready4); end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    d = 8'b0000_0101; amt = 3'd3; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", lat); end
    checks++; if (out !== 8'b0010_1000) begin errors++; $display("FAIL basic_out got %h exp 28", out); end
`ifdef SLL_STICKY_EN
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL basic_sticky got %b exp 0", sticky); end
`endif
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    d = 8'hA5; amt = 3'd0; in_valid = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL amt0_valid got %b exp 1", out_valid); end
    checks++; if (out !== 8'hA5) begin errors++; $display("FAIL amt0_out got %h exp a5", out); end
    d = 8'h01; amt = 3'd1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_shift_valid got %b exp 0", out_valid); end
    checks++; if (out !== 8'h01) begin errors++; $display("FAIL b2b_loaded got %h exp 01", out); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
    checks++; if (out !== 8'h02) begin errors++; $display("FAIL b2b_out got %h exp 02", out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    int lat;
    out_ready = 1'b1;
    d4 = 4'hF; amt4 = 3'd6; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL sat_busy got %b exp 1", busy4); end
    lat = 0;
    while (!out_valid4 && lat < 50) begin tick(); lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL sat_latency got %0d exp 4", lat); end
    checks++; if (out4 !== 4'h0) begin errors++; $display("FAIL sat_out got %h exp 0", out4); end
`ifdef SLL_STICKY_EN
    checks++; if (sticky4 !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b exp 1", sticky4); end
`endif
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL sat_drained got %b exp 0", out_valid4); end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    d = 8'h11; amt = 3'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    checks++; if (lat !== 2) begin errors++; $display("FAIL bp_latency got %0d exp 2", lat); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b exp 1", i, out_valid); end
      checks++; if (out !== 8'h44) begin errors++; $display("FAIL bp_hold_out cycle %0d got %h exp 44", i, out); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b exp 0", i, in_ready); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_enable();
    int lat;
    out_ready = 1'b1;
    d = 8'h03; amt = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      en = !(lat >= 1 && lat < 4);
      tick();
      lat++;
      if (lat == 3) begin
        checks++; if (out !== 8'h06) begin errors++; $display("FAIL en_hold_out got %h exp 06", out); end
      end
    end
    en = 1'b1;
    checks++; if (lat !== 8) begin errors++; $display("FAIL en_latency got %0d exp 8", lat); end
    checks++; if (out !== 8'h60) begin errors++; $display("FAIL en_out got %h exp 60", out); end
    en = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL en_no_transfer got %b exp 1", out_valid); end
    en = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    d = 8'h81; amt = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (out !== 8'h04) begin errors++; $display("FAIL rmid_pre_out got %h exp 04", out); end
    rst = 1'b0;
    #1;
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL rmid_out got %h exp 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_result cycle %0d got %b exp 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
